// File: rtl/register_file_pkg.sv
// Shared sizing constants for the 32 x 32-bit architectural register file.
package register_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/register32.sv
// 32-bit storage register with load enable and asynchronous active-low clear.
module register32
  import register_file_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeEnable,
  input  logic [0:DATA_WIDTH-1]   d,
  output logic [0:DATA_WIDTH-1]   q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (writeEnable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file; r0 is hard-wired to zero and reads are
// purely combinational from storage (no write-to-read bypass).
module register_file
  import register_file_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeEnable,
  input  logic [0:ADDR_WIDTH-1]   writeReg,
  input  logic [0:DATA_WIDTH-1]   writeData,
  input  logic [0:ADDR_WIDTH-1]   readRegA,
  input  logic [0:ADDR_WIDTH-1]   readRegB,
  output logic [0:DATA_WIDTH-1]   readDataA,
  output logic [0:DATA_WIDTH-1]   readDataB
);

  logic [1:NUM_REGS-1]   regWe;
  logic [0:DATA_WIDTH-1] regQ [NUM_REGS];

  // One-hot 5-to-32 decode; slot 0 has no storage, so it gets no enable.
  always_comb begin
    regWe = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regWe[i] = writeEnable && (writeReg == ADDR_WIDTH'(i));
    end
  end

  assign regQ[ZERO_REG] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : gRegs
    register32 uReg (
      .clk         (clk),
      .reset       (reset),
      .writeEnable (regWe[g]),
      .d           (writeData),
      .q           (regQ[g])
    );
  end

  assign readDataA = regQ[readRegA];
  assign readDataB = regQ[readRegB];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed literal checks plus randomized traffic
// compared every cycle against an array model of the register contents.
`timescale 1ns/10ps
module tb_register_file;
  import register_file_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  writeEnable = 1'b0;
  logic [0:ADDR_WIDTH-1] writeReg = '0;
  logic [0:DATA_WIDTH-1] writeData = '0;
  logic [0:ADDR_WIDTH-1] readRegA = '0;
  logic [0:ADDR_WIDTH-1] readRegB = '0;
  logic [0:DATA_WIDTH-1] readDataA;
  logic [0:DATA_WIDTH-1] readDataB;

  int nVectors = 0;
  int nMiscompares = 0;
  bit checking = 1'b0;
  logic [31:0] model [32];

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .readRegA    (readRegA),
    .readRegB    (readRegB),
    .readDataA   (readDataA),
    .readDataB   (readDataB)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: a plain array updated by the architectural rules
  initial for (int i = 0; i < 32; i++) model[i] = 32'h0;

  always @(negedge reset) begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (reset === 1'b1 && writeEnable === 1'b1 && writeReg != 5'd0)
      model[writeReg] = writeData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model, mid-cycle away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      check("portA_model", readDataA, (reset === 1'b1) ? model[readRegA] : 32'h0);
      check("portB_model", readDataB, (reset === 1'b1) ? model[readRegB] : 32'h0);
    end
  end

  // driver: change inputs just after a rising edge
  task automatic setIn(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    writeEnable = we;
    writeReg    = wr;
    writeData   = wd;
    readRegA    = ra;
    readRegB    = rb;
  endtask

  initial begin
    // reset held from time zero: outputs must already be clear
    #2;
    check("reset_init_A", readDataA, 32'h0);
    check("reset_init_B", readDataB, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    checking = 1'b1;

    // basic write/read
    setIn(1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd31);
    setIn(1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31);
    setIn(1'b0, 5'd0,  32'h0,        5'd5, 5'd31);
    #2;
    check("r5_write", readDataA, 32'hDEADBEEF);
    check("r31_write", readDataB, 32'h12345678);
    readRegA = 5'd6;
    #1;
    check("r6_zero", readDataA, 32'h0);

    // r0 immunity
    setIn(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    setIn(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2;
    check("r0_immune", readDataA, 32'h0);

    // same-cycle read/write: old value before the edge, new value after
    setIn(1'b1, 5'd7, 32'h00000001, 5'd7, 5'd7);
    setIn(1'b1, 5'd7, 32'h00000002, 5'd7, 5'd7);
    #2;
    check("r7_before_edge", readDataA, 32'h00000001);
    @(posedge clk);
    #1;
    check("r7_after_edge", readDataA, 32'h00000002);
    writeEnable = 1'b0;

    // write-enable gating over three edges
    setIn(1'b0, 5'd9, 32'hAAAAAAAA, 5'd9, 5'd9);
    repeat (3) @(posedge clk);
    #1;
    check("r9_gated", readDataA, 32'h0);

    // reset mid-operation while writing r3
    setIn(1'b1, 5'd3, 32'h55555555, 5'd3, 5'd3);
    setIn(1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3);
    #2;
    check("r3_loaded", readDataA, 32'h55555555);
    reset = 1'b0;
    #0.5;
    check("r3_async_clear", readDataA, 32'h0);
    @(posedge clk);
    #1;
    check("r3_held_in_reset", readDataA, 32'h0);
    writeEnable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("r3_after_release", readDataA, 32'h0);
    // first valid write after release
    writeEnable = 1'b1;
    writeReg    = 5'd3;
    writeData   = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("r3_first_write", readDataA, 32'hCAFEF00D);
    writeEnable = 1'b0;

    // reset with random prior contents: every index reads zero before any edge
    for (int i = 0; i < 40; i++)
      setIn(1'b1, 5'($urandom_range(0, 31)), $urandom, 5'd0, 5'd0);
    setIn(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readRegA = 5'(i);
      readRegB = 5'(31 - i);
      #0.1;
      check("reset_sweep_A", readDataA, 32'h0);
      check("reset_sweep_B", readDataB, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;

    // randomized traffic with occasional mid-cycle reset pulses
    for (int i = 0; i < 2000; i++) begin
      setIn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
      end
    end

    // same index on both ports must agree
    setIn(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #2;
    check("same_index_ports", readDataA, readDataB);

    @(posedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset, and this polarity and synchronicity are fixed.
REQ-002 The block SHALL expose exactly these ports, with all buses numbered [0:N-1] and bit 0 the MSB:
- clk  input  1  rising-edge clock for all state
- reset  input  1  asynchronous active-low reset; 0 clears all storage
- writeEnable  input  1  1 = commit writeData to writeReg at next rising clk edge
- writeReg  input  5  destination register index
- writeData  input  32  data to store
- readRegA  input  5  read port A index
- readRegB  input  5  read port B index
- readDataA  output  32  contents of register readRegA
- readDataB  output  32  contents of register readRegB
REQ-003 The block SHALL have no parameters; sizes come from the shared package constants (REQ-016).

Function
REQ-004 The block SHALL hold 32 architectural registers r0..r31, each 32 bits wide.
REQ-005 r0 SHALL always read 0x00000000; writes addressed to r0 SHALL be discarded without error.
REQ-006 A write SHALL occur only on a rising clk edge with writeEnable=1 and reset=1; exactly one register (writeReg) is updated, and all others hold.
REQ-007 With writeEnable=0, no register SHALL change regardless of writeReg or writeData.
REQ-008 Reads SHALL be combinational: readDataA/B reflect current storage for readRegA/B with zero cycle latency, and change within the same cycle when the index changes.
REQ-009 There SHALL be no write-to-read bypass: a read of a register being written in the same cycle returns the old value until the clk edge, and the new value immediately after.
REQ-010 Both read ports SHALL be independent; readRegA=readRegB SHALL return identical data on both ports.
REQ-011 Back-to-back writes to the same register on consecutive edges SHALL each take effect; the last one wins.
REQ-012 Write decode SHALL be one-hot: at most one register's writeEnable is asserted per cycle, derived from writeEnable AND decode(writeReg).

Reset
REQ-013 Asserting reset low SHALL immediately, without waiting for clk, force r1..r31 to 0x00000000, and readDataA/B SHALL read 0x00000000 for every index.
REQ-014 While reset=0, writes SHALL be ignored; if reset is asserted mid-write, the cleared value wins.
REQ-015 After reset is released, the first write SHALL take effect on the first rising edge at which reset=1 and writeEnable=1.

Structure
REQ-016 A shared package SHALL define DATA_WIDTH=32, ADDR_WIDTH=5, NUM_REGS=32, and ZERO_REG=0; the package is also used by the datapath and control.
REQ-017 Storage SHALL be 31 instances of the team's 32-bit register sub-module (register32) for r1..r31, each driven by the shared clk and reset and its own decoded writeEnable; r0 SHALL be a constant, not storage.
REQ-018 Read ports SHALL be two 32:1 32-bit multiplexers; the write decoder SHALL be a 5-to-32 decoder, either inline or as one sub-module named decoder5to32.
REQ-019 The block SHALL contain no latches, and no combinational path from writeData to readDataA/B.

Verification
REQ-020 Reset: drive reset=0 with random prior contents -> all 32 indices read 0x00000000 on both ports before any clk edge.
REQ-021 Basic write/read: write 0xDEADBEEF to r5 and 0x12345678 to r31 -> readRegA=5 gives 0xDEADBEEF and readRegB=31 gives 0x12345678; r6 reads 0.
REQ-022 r0 immunity: writeEnable=1, writeReg=0, writeData=0xFFFFFFFF, then clock -> readRegA=0 gives 0x00000000.
REQ-023 Same-cycle read/write: r7=0x00000001, then write 0x00000002 to r7 while readRegA=7 -> 0x00000001 before the edge and 0x00000002 after it.
REQ-024 Write-enable gating: writeEnable=0, writeReg=9, writeData=0xAAAAAAAA over 3 edges -> r9 stays at its prior value of 0x0.
REQ-025 Reset mid-operation: r3=0x55555555, then pull reset low between edges while writing r3 -> r3 reads 0x00000000 immediately and after release until the next valid write.
